// File: rtl/shift_sequencer_if.sv
// Command/response handshake bundle for shift_sequencer.
// cmd_rotate is present only when SHIFT_SEQ_ROTATE_EN is defined.
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int RSP_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic [RSP_W-1:0] cmd_serial;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic             cmd_rotate;
`endif
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RSP_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_serial, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
`ifdef SHIFT_SEQ_ROTATE_EN
        , output cmd_rotate
`endif
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_serial, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
`ifdef SHIFT_SEQ_ROTATE_EN
        , input cmd_rotate
`endif
    );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven load/shift controller for the parallel-load serial shift register.
// Optional rotate mode (cmd_rotate, sr_parallel_out) enabled by SHIFT_SEQ_ROTATE_EN.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int RSP_W = 8
) (
    input  logic             clk_in,
    input  logic             n_rst_in,
    shift_sequencer_if.slave bus,
    output logic [WIDTH-1:0] sr_parallel_in,
    output logic             sr_parallel_load,
    output logic             sr_shift_r,
    output logic             sr_shift_l,
    output logic             sr_seq_in,
    input  logic             sr_seq_out
`ifdef SHIFT_SEQ_ROTATE_EN
    ,
    input  logic [WIDTH-1:0] sr_parallel_out
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_t;

    state_t           state, state_d;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RSP_W-1:0] ser_q;
    logic [RSP_W:0]   mask_q;
    logic [RSP_W-1:0] rsp_data_q;
    logic             rsp_valid_q;
    logic             seq_q;
    logic             load_d, shr_d, shl_d, seq_d, valid_d;
    logic             accept;

    assign accept        = bus.cmd_valid && (state == IDLE);
    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) state <= IDLE;
        else           state <= state_d;
    end

    always_comb begin
        state_d = state;
        load_d  = 1'b0;
        shr_d   = 1'b0;
        shl_d   = 1'b0;
        seq_d   = 1'b0;
        valid_d = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = LOAD;
                    load_d  = 1'b1;
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d = SHIFT;
                    shr_d   = ~dir_q;
                    shl_d   = dir_q;
                    seq_d   = ser_q[0];
                end
            end
            SHIFT: begin
                // cnt_q holds the strobes still to issue, including the current one
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    shr_d = ~dir_q;
                    shl_d = dir_q;
                    seq_d = ser_q[0];
                end
            end
            DRAIN: begin
                state_d = DONE;
                valid_d = 1'b1;
            end
            DONE: begin
                if (bus.rsp_ready) state_d = IDLE;
                else               valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_q;
`endif

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            sr_parallel_in   <= '0;
            sr_parallel_load <= 1'b0;
            sr_shift_r       <= 1'b0;
            sr_shift_l       <= 1'b0;
            seq_q            <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            dir_q            <= 1'b0;
            cnt_q            <= '0;
            ser_q            <= '0;
            mask_q           <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q            <= 1'b0;
`endif
        end else begin
            sr_parallel_load <= load_d;
            sr_shift_r       <= shr_d;
            sr_shift_l       <= shl_d;
            seq_q            <= seq_d;
            rsp_valid_q      <= valid_d;
            if (accept) begin
                sr_parallel_in <= bus.cmd_data;
                dir_q          <= bus.cmd_dir;
                cnt_q          <= bus.cmd_count;
                ser_q          <= bus.cmd_serial;
                rsp_data_q     <= '0;
                mask_q         <= {{RSP_W{1'b0}}, 1'b1};
`ifdef SHIFT_SEQ_ROTATE_EN
                rot_q          <= bus.cmd_rotate;
`endif
            end
            // mask bit 0 covers the first strobe cycle, which has nothing to sample yet;
            // once the one-hot walks off the top, later bits are discarded
            if (state == SHIFT || state == DRAIN) begin
                rsp_data_q <= rsp_data_q | (mask_q[RSP_W:1] & {RSP_W{sr_seq_out}});
                mask_q     <= mask_q << 1;
            end
            if (state == SHIFT) cnt_q <= cnt_q - CNT_W'(1);
            if (state_d == SHIFT) ser_q <= ser_q >> 1;
        end
    end

`ifdef SHIFT_SEQ_ROTATE_EN
    assign sr_seq_in = (rot_q && state == SHIFT)
                     ? (dir_q ? sr_parallel_out[WIDTH-1] : sr_parallel_out[0])
                     : seq_q;
`else
    assign sr_seq_in = seq_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer with a behavioural shift-register and bit-stream model.
// Rotate checks are added when SHIFT_SEQ_ROTATE_EN is defined.
module tb_shift_sequencer;
    localparam int W = 4;
    localparam int C = 4;
    localparam int R = 8;

    logic         clk_in = 1'b0;
    logic         n_rst_in = 1'b0;
    logic [W-1:0] sr_parallel_in;
    logic         sr_parallel_load, sr_shift_r, sr_shift_l, sr_seq_in;
    logic         sr_seq_out;
    logic [W-1:0] sr_reg;
    int           n_tests = 0;
    int           n_fail = 0;
    int           n_load = 0, n_r = 0, n_l = 0;
    logic [R-1:0] got;

    always #5 clk_in = ~clk_in;

    shift_sequencer_if #(.WIDTH(W), .CNT_W(C), .RSP_W(R)) bus ();

    shift_sequencer #(.WIDTH(W), .CNT_W(C), .RSP_W(R)) dut (
        .clk_in          (clk_in),
        .n_rst_in        (n_rst_in),
        .bus             (bus),
        .sr_parallel_in  (sr_parallel_in),
        .sr_parallel_load(sr_parallel_load),
        .sr_shift_r      (sr_shift_r),
        .sr_shift_l      (sr_shift_l),
        .sr_seq_in       (sr_seq_in),
        .sr_seq_out      (sr_seq_out)
`ifdef SHIFT_SEQ_ROTATE_EN
        ,
        .sr_parallel_out (sr_reg)
`endif
    );

    // Downstream shift register: seq_out is registered, valid the cycle after a shift edge
    always @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            sr_reg     <= '0;
            sr_seq_out <= 1'b0;
        end else if (sr_parallel_load) begin
            sr_reg <= sr_parallel_in;
        end else if (sr_shift_r) begin
            sr_seq_out <= sr_reg[0];
            sr_reg     <= {sr_seq_in, sr_reg[W-1:1]};
        end else if (sr_shift_l) begin
            sr_seq_out <= sr_reg[W-1];
            sr_reg     <= {sr_reg[W-2:0], sr_seq_in};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (n_rst_in) begin
            n_load += int'(sr_parallel_load);
            n_r    += int'(sr_shift_r);
            n_l    += int'(sr_shift_l);
            check("strobe_excl", {30'd0, sr_shift_r & sr_shift_l,
                                  sr_parallel_load & (sr_shift_r | sr_shift_l)}, 0);
        end
    end

    function automatic logic [17:0] out_vec();
        return {bus.cmd_ready, bus.rsp_valid, sr_parallel_load, sr_shift_r, sr_shift_l,
                sr_seq_in, sr_parallel_in, bus.rsp_data};
    endfunction

    // Bit p of the serial stream leaving the register: load word first, then what was shifted in
    function automatic logic stream_bit(logic [W-1:0] d, logic dir, logic rot, logic [R-1:0] ser, int p);
        int q;
        if (p < W || rot) begin
            q = p % W;
            return dir ? d[W-1-q] : d[q];
        end
        if (p - W < R) return ser[p-W];
        return 1'b0;
    endfunction

    function automatic logic [R-1:0] model_rsp(logic [W-1:0] d, logic dir, logic rot, logic [R-1:0] ser, int cnt);
        logic [R-1:0] r = '0;
        for (int i = 0; i < R; i++)
            if (i < cnt) r[i] = stream_bit(d, dir, rot, ser, i);
        return r;
    endfunction

    function automatic logic [W-1:0] model_reg(logic [W-1:0] d, logic dir, logic rot, logic [R-1:0] ser, int cnt);
        logic [W-1:0] r = '0;
        for (int j = 0; j < W; j++) begin
            if (dir) r[W-1-j] = stream_bit(d, dir, rot, ser, cnt + j);
            else     r[j]     = stream_bit(d, dir, rot, ser, cnt + j);
        end
        return r;
    endfunction

    task automatic run_cmd(input logic [W-1:0] d, input logic dir, input logic [C-1:0] cnt,
                           input logic [R-1:0] ser, input logic rot, input int hold,
                           output logic [R-1:0] rsp);
        int lat;
        @(negedge clk_in);
        check("ready_idle", bus.cmd_ready, 1);
        n_load = 0; n_r = 0; n_l = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_data   = d;
        bus.cmd_dir    = dir;
        bus.cmd_count  = cnt;
        bus.cmd_serial = ser;
`ifdef SHIFT_SEQ_ROTATE_EN
        bus.cmd_rotate = rot;
`endif
        @(posedge clk_in); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_data   = W'($urandom);
        bus.cmd_dir    = 1'($urandom);
        bus.cmd_count  = C'($urandom);
        bus.cmd_serial = R'($urandom);
        bus.rsp_ready  = 1'($urandom);
        check("ready_busy", bus.cmd_ready, 0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk_in); lat++; #1;
            if (bus.rsp_valid) break;
        end
        bus.rsp_ready = 1'b0;
        if (!bus.rsp_valid) begin
            check("rsp_timeout", 0, 1);
            rsp = '0;
            n_rst_in = 1'b0; #3; n_rst_in = 1'b1;
            return;
        end
        rsp = bus.rsp_data;
        check("latency", lat, (cnt == 0) ? 1 : int'(cnt) + 2);
        check("rsp_data", rsp, model_rsp(d, dir, rot, ser, int'(cnt)));
        check("reg_final", sr_reg, model_reg(d, dir, rot, ser, int'(cnt)));
        check("n_load", n_load, 1);
        check("n_strobe", dir ? n_l : n_r, int'(cnt));
        check("n_wrongdir", dir ? n_r : n_l, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_in);
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = W'($urandom);
            bus.cmd_count = C'($urandom);
            @(posedge clk_in); #1;
            check("hold_vec", {bus.rsp_valid, bus.cmd_ready, bus.rsp_data}, {2'b10, rsp});
        end
        @(negedge clk_in);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk_in); #1;
        bus.rsp_ready = 1'b0;
        check("rsp_release", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    endtask

    task automatic reset_mid_shift();
        @(negedge clk_in);
        bus.cmd_valid  = 1'b1;
        bus.cmd_data   = 4'b1010;
        bus.cmd_dir    = 1'b0;
        bus.cmd_count  = 4'd10;
        bus.cmd_serial = R'($urandom);
`ifdef SHIFT_SEQ_ROTATE_EN
        bus.cmd_rotate = 1'b0;
`endif
        @(posedge clk_in); #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("mid_busy", sr_shift_r, 1);
        #2 n_rst_in = 1'b0;
        #1 check("mid_rst_vec", out_vec(), {1'b1, 17'd0});
        @(negedge clk_in);
        n_rst_in = 1'b1;
        repeat (12) begin
            @(posedge clk_in); #1;
            check("mid_no_rsp", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_data   = '0;
        bus.cmd_dir    = 1'b0;
        bus.cmd_count  = '0;
        bus.cmd_serial = '0;
        bus.rsp_ready  = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
        bus.cmd_rotate = 1'b0;
`endif
        repeat (3) @(negedge clk_in);
        check("rst_vec", out_vec(), {1'b1, 17'd0});
        n_rst_in = 1'b1;
        repeat (10) begin
            @(posedge clk_in); #1;
            check("idle_vec", out_vec(), {1'b1, 17'd0});
        end

        run_cmd(4'b1011, 1'b0, 4'd4, 8'h00, 1'b0, 0, got);
        check("right_0B", got, 8'h0B);
        run_cmd(4'b1011, 1'b1, 4'd4, 8'h00, 1'b0, 0, got);
        check("left_0D", got, 8'h0D);
        run_cmd(4'b0000, 1'b0, 4'd6, 8'h03, 1'b0, 5, got);
        check("serial_30", got, 8'h30);
        run_cmd(4'b1011, 1'b0, 4'd0, 8'hFF, 1'b0, 0, got);
        check("count0", got, 8'h00);
        run_cmd(4'b0110, 1'b0, 4'd15, 8'hA5, 1'b0, 1, got);
        run_cmd(4'b0110, 1'b1, 4'd15, 8'h5A, 1'b0, 0, got);

        reset_mid_shift();

`ifdef SHIFT_SEQ_ROTATE_EN
        run_cmd(4'b1001, 1'b0, 4'd4, 8'hFF, 1'b1, 0, got);
        check("rot_09", got, 8'h09);
        check("rot_reg", sr_reg, 4'b1001);
`endif

        for (int n = 0; n < 40; n++) begin
            logic rot;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot = 1'($urandom);
`else
            rot = 1'b0;
`endif
            run_cmd(W'($urandom), 1'($urandom), C'($urandom_range(0, 15)), R'($urandom),
                    rot, $urandom_range(0, 3), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
